// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional grant counters are built when ALU_ARB_CNT_EN is defined.

module Alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    input  logic        unsig,
    output logic [31:0] aluout,
    output logic        compout,
    output logic        overflow
);

    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic        w_add_ovf;
    logic        w_sub_ovf;

    assign w_sum  = a + b;
    assign w_diff = a - b;

    assign w_add_ovf = (a[31] == b[31]) && (w_sum[31] != a[31]);
    assign w_sub_ovf = (a[31] != b[31]) && (w_diff[31] != a[31]);

    // Result select, signed/unsigned less-than, signed overflow
    always_comb begin
        aluout   = 32'h0;
        overflow = 1'b0;
        case (op)
            3'b000: aluout = a & b;
            3'b001: aluout = a | b;
            3'b010: begin
                aluout   = w_sum;
                overflow = w_add_ovf & ~unsig;
            end
            3'b100: aluout = ~(a | b);
            3'b101: aluout = a ^ b;
            3'b110: begin
                aluout   = w_diff;
                overflow = w_sub_ovf & ~unsig;
            end
            default: aluout = 32'h0;
        endcase
        if (unsig)
            compout = (a < b);
        else
            compout = ($signed(a) < $signed(b));
    end

endmodule

module alu_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req0_unsig,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    input  logic        req1_unsig,
    output logic        req1_ready,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_aluout,
    output logic        rsp_compout,
    output logic        rsp_overflow,
    input  logic        rsp_ready,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1
);

    logic        r_prio;
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [31:0] r_rsp_aluout;
    logic        r_rsp_compout;
    logic        r_rsp_overflow;

    logic        w_free;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_gnt;

    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [2:0]  w_op;
    logic        w_unsig;

    logic [31:0] w_alu_out;
    logic        w_alu_comp;
    logic        w_alu_ovf;

    logic        w_kill;
    logic        w_ovf_ok;
    logic [31:0] w_cap_out;
    logic        w_cap_ovf;

    // The slot is free when empty or being drained this cycle
    assign w_free = ~r_rsp_valid | rsp_ready;

    // Round-robin: a lone requester wins, contention goes to r_prio
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset && w_free) begin
            if (req0_valid && (!req1_valid || !r_prio))
                w_gnt0 = 1'b1;
            else if (req1_valid)
                w_gnt1 = 1'b1;
        end
    end

    assign w_gnt      = w_gnt0 | w_gnt1;
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Steer the granted requester onto the shared datapath
    always_comb begin
        w_a     = req0_a;
        w_b     = req0_b;
        w_op    = req0_op;
        w_unsig = req0_unsig;
        if (w_gnt1) begin
            w_a     = req1_a;
            w_b     = req1_b;
            w_op    = req1_op;
            w_unsig = req1_unsig;
        end
    end

    Alu u_alu (
        .a        (w_a),
        .b        (w_b),
        .op       (w_op),
        .unsig    (w_unsig),
        .aluout   (w_alu_out),
        .compout  (w_alu_comp),
        .overflow (w_alu_ovf)
    );

    // Undefined ops read as zero; overflow only means something on signed add/sub
    assign w_kill    = (w_op == 3'b011) || (w_op == 3'b111);
    assign w_ovf_ok  = ((w_op == 3'b010) || (w_op == 3'b110)) && !w_unsig;
    assign w_cap_out = w_kill ? 32'h0 : w_alu_out;
    assign w_cap_ovf = w_ovf_ok & w_alu_ovf & ~w_kill;

    // Priority flips away from whoever was just granted
    always_ff @(posedge clock) begin
        if (reset)
            r_prio <= 1'b0;
        else if (w_gnt)
            r_prio <= w_gnt0;
    end

    // One-entry response register; a grant overwrites a consumed entry
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= 1'b0;
            r_rsp_aluout   <= 32'h0;
            r_rsp_compout  <= 1'b0;
            r_rsp_overflow <= 1'b0;
        end else if (w_gnt) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_id       <= w_gnt1;
            r_rsp_aluout   <= w_cap_out;
            r_rsp_compout  <= w_alu_comp;
            r_rsp_overflow <= w_cap_ovf;
        end else if (rsp_ready) begin
            r_rsp_valid    <= 1'b0;
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_aluout   = r_rsp_aluout;
    assign rsp_compout  = r_rsp_compout;
    assign rsp_overflow = r_rsp_overflow;

`ifdef ALU_ARB_CNT_EN
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    // Saturating per-requester grant counters
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt0 <= 16'h0;
            r_cnt1 <= 16'h0;
        end else begin
            if (w_gnt0 && (r_cnt0 != 16'hFFFF))
                r_cnt0 <= r_cnt0 + 16'd1;
            if (w_gnt1 && (r_cnt1 != 16'hFFFF))
                r_cnt1 <= r_cnt1 + 16'd1;
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`else
    assign cnt0 = 16'h0;
    assign cnt1 = 16'h0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table plus scoreboard.
// Counter saturation is exercised when ALU_ARB_CNT_EN is defined.

module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        v0, v1, u0, u1;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  op0, op1;
    logic        rdy0, rdy1;
    logic        rsp_valid, rsp_id, rsp_comp, rsp_ovf, rsp_ready;
    logic [31:0] rsp_out;
    logic [15:0] cnt0, cnt1;

    typedef struct packed {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        unsig;
        logic [31:0] out;
        logic        comp;
        logic        ovf;
    } vec_t;

    typedef struct packed {
        logic        id;
        logic [31:0] out;
        logic        comp;
        logic        ovf;
    } rsp_t;

    vec_t vt [12];
    rsp_t sb [$];
    int   n_chk = 0;
    int   n_err = 0;

    alu_arbiter dut (
        .clock        (clk),
        .reset        (rst),
        .req0_valid   (v0),
        .req0_a       (a0),
        .req0_b       (b0),
        .req0_op      (op0),
        .req0_unsig   (u0),
        .req0_ready   (rdy0),
        .req1_valid   (v1),
        .req1_a       (a1),
        .req1_b       (b1),
        .req1_op      (op1),
        .req1_unsig   (u1),
        .req1_ready   (rdy1),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_aluout   (rsp_out),
        .rsp_compout  (rsp_comp),
        .rsp_overflow (rsp_ovf),
        .rsp_ready    (rsp_ready),
        .cnt0         (cnt0),
        .cnt1         (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        v0 = 0; a0 = 0; b0 = 0; op0 = 0; u0 = 0;
        v1 = 0; a1 = 0; b1 = 0; op1 = 0; u1 = 0;
    endtask

    task automatic set0(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic u);
        v0 = 1; a0 = a; b0 = b; op0 = op; u0 = u;
    endtask

    task automatic set1(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic u);
        v1 = 1; a1 = a; b1 = b; op1 = op; u1 = u;
    endtask

    // Scoreboard: every consumed response is compared with the oldest expectation
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL rsp_unexpected: got %0h want none",
                         {rsp_id, rsp_out, rsp_comp, rsp_ovf});
            end else begin
                chk("rsp", {rsp_id, rsp_out, rsp_comp, rsp_ovf},
                    sb.pop_front());
            end
        end
    end

    initial begin
        vt[0]  = '{1'b1, 32'h7FFFFFFF, 32'h1, 3'b010, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vt[1]  = '{1'b1, 32'h7FFFFFFF, 32'h1, 3'b010, 1'b1, 32'h80000000, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 32'hFFFFFFFF, 32'h1, 3'b000, 1'b0, 32'h1, 1'b1, 1'b0};
        vt[3]  = '{1'b0, 32'hFFFFFFFF, 32'h1, 3'b000, 1'b1, 32'h1, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b111, 1'b0, 32'h0, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 32'h0F0F0000, 32'hF0, 3'b001, 1'b0, 32'h0F0F00F0, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 32'h0, 32'h0, 3'b100, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 32'hA5A5A5A5, 32'hFFFF0000, 3'b101, 1'b0, 32'h5A5AA5A5, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 32'h80000000, 32'h1, 3'b110, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
        vt[9]  = '{1'b0, 32'h3, 32'h5, 3'b110, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0};
        vt[10] = '{1'b1, 32'h5, 32'h3, 3'b011, 1'b0, 32'h0, 1'b0, 1'b0};
        vt[11] = '{1'b0, 32'h1, 32'h1, 3'b010, 1'b0, 32'h2, 1'b0, 1'b0};

        // Reset with both requesters pending
        rst = 1;
        rsp_ready = 1;
        clr_req();
        set0(32'd5, 32'd7, 3'b010, 1'b0);
        set1(32'd9, 32'd4, 3'b110, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", rdy0, 0);
        chk("rst_ready1", rdy1, 0);
        chk("rst_rsp", {rsp_valid, rsp_id, rsp_out, rsp_comp, rsp_ovf}, 0);
        chk("rst_cnt", {cnt0, cnt1}, 0);
        step();
        rst = 0;

        // Continuous contention alternates 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("alt_ready0_%0d", k), rdy0, (k % 2) == 0);
            chk($sformatf("alt_ready1_%0d", k), rdy1, (k % 2) == 1);
            if ((k % 2) == 0)
                sb.push_back('{1'b0, 32'd12, 1'b1, 1'b0});
            else
                sb.push_back('{1'b1, 32'd5, 1'b0, 1'b0});
            step();
        end
        clr_req();

        // Back-to-back single-requester vectors
        for (int i = 0; i < 12; i++) begin
            clr_req();
            if (vt[i].id)
                set1(vt[i].a, vt[i].b, vt[i].op, vt[i].unsig);
            else
                set0(vt[i].a, vt[i].b, vt[i].op, vt[i].unsig);
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), {rdy1, rdy0},
                vt[i].id ? 2'b10 : 2'b01);
            sb.push_back('{vt[i].id, vt[i].out, vt[i].comp, vt[i].ovf});
            step();
        end
        clr_req();
        repeat (2) step();

        // Backpressure holds the response and blocks grants
        rsp_ready = 0;
        set0(32'd1, 32'd2, 3'b010, 1'b0);
        @(negedge clk);
        chk("bp_first_ready", rdy0, 1);
        sb.push_back('{1'b0, 32'd3, 1'b1, 1'b0});
        step();
        set0(32'd10, 32'd20, 3'b010, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_stall_ready_%0d", k), rdy0, 0);
            chk($sformatf("bp_hold_%0d", k), {rsp_valid, rsp_out}, {1'b1, 32'd3});
            step();
        end
        rsp_ready = 1;
        @(negedge clk);
        chk("bp_release_ready", rdy0, 1);
        sb.push_back('{1'b0, 32'd30, 1'b1, 1'b0});
        step();
        clr_req();
        repeat (2) step();

        // Reset mid-operation drops the response and restores prio
        rsp_ready = 0;
        set0(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b111, 1'b0);
        @(negedge clk);
        chk("mid_grant", rdy0, 1);
        step();
        chk("mid_held", rsp_valid, 1);
        rst = 1;
        set0(32'd5, 32'd7, 3'b010, 1'b0);
        set1(32'd9, 32'd4, 3'b110, 1'b0);
        @(negedge clk);
        chk("mid_rst_ready", {rdy1, rdy0}, 2'b00);
        step();
        rst = 0;
        rsp_ready = 1;
        @(negedge clk);
        chk("mid_rsp_cleared", rsp_valid, 0);
        chk("mid_prio_ready", {rdy1, rdy0}, 2'b01);
        sb.push_back('{1'b0, 32'd12, 1'b1, 1'b0});
        step();
        clr_req();
        repeat (2) step();

        // Grant counters
        rst = 1;
        step();
        rst = 0;
        set0(32'd1, 32'd1, 3'b010, 1'b0);
`ifdef ALU_ARB_CNT_EN
        for (int n = 0; n < 70000; n++) begin
            @(negedge clk);
            if (n == 0)
                chk("cnt_first_ready", rdy0, 1);
            sb.push_back('{1'b0, 32'd2, 1'b0, 1'b0});
            step();
        end
        clr_req();
        @(negedge clk);
        chk("cnt0_sat", cnt0, 16'hFFFF);
        chk("cnt1_zero", cnt1, 16'h0);
`else
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk($sformatf("cnt0_tied_%0d", n), cnt0, 16'h0);
            sb.push_back('{1'b0, 32'd2, 1'b0, 1'b0});
            step();
        end
        clr_req();
        @(negedge clk);
        chk("cnt_tied", {cnt0, cnt1}, 32'h0);
`endif
        repeat (3) step();
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
